// File: rtl/exe_operand_stage.sv
// ID->EX operand register with load-use hazard detection; E/M forwarding when EXE_OPERAND_FWD_EN is defined.
// One-cycle d_* -> e_* latency; stall holds the stage, flush/stall_req insert bubbles, stall_req is combinational.
module exe_operand_stage #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         d_valid,
  input  logic         d_wreg,
  input  logic         d_m2reg,
  input  logic         d_wmem,
  input  logic         d_aluimm,
  input  logic         d_shift,
  input  logic         d_use_rs,
  input  logic         d_use_rt,
  input  logic [3:0]   d_aluc,
  input  logic [4:0]   d_rs,
  input  logic [4:0]   d_rt,
  input  logic [4:0]   d_rn,
  input  logic [4:0]   d_sa,
  input  logic [W-1:0] d_qa,
  input  logic [W-1:0] d_qb,
  input  logic [W-1:0] d_imm,
  input  logic [W-1:0] ex_alu,
  input  logic         m_wreg,
  input  logic         m_m2reg,
  input  logic [4:0]   m_rn,
  input  logic [W-1:0] m_data,
  input  logic         stall,
  input  logic         flush,
  output logic [W-1:0] e_a,
  output logic [W-1:0] e_b,
  output logic [3:0]   e_aluc,
  output logic         e_wreg,
  output logic         e_m2reg,
  output logic         e_wmem,
  output logic         e_valid,
  output logic [4:0]   e_rn,
  output logic         stall_req,
  output logic [15:0]  stall_cnt
);

  logic         src_rs;
  logic         src_rt;
  logic         e_hit_rs;
  logic         e_hit_rt;
  logic         m_hit_rs;
  logic         m_hit_rt;
  logic [W-1:0] fwd_a;
  logic [W-1:0] fwd_b;
  logic         unused_in;

  // r0 is hardwired zero, so it never creates a dependency
  assign src_rs   = d_valid & d_use_rs & (d_rs != 5'd0);
  assign src_rt   = d_valid & d_use_rt & (d_rt != 5'd0);
  assign e_hit_rs = e_valid & e_wreg & (e_rn == d_rs);
  assign e_hit_rt = e_valid & e_wreg & (e_rn == d_rt);
  assign m_hit_rs = m_wreg & (m_rn == d_rs);
  assign m_hit_rt = m_wreg & (m_rn == d_rt);

`ifdef EXE_OPERAND_FWD_EN
  // Only a load in E cannot be bypassed: its data is not ready until M.
  assign stall_req = (src_rs & e_hit_rs & e_m2reg) | (src_rt & e_hit_rt & e_m2reg);
  assign unused_in = m_m2reg;

  always_comb begin
    fwd_a = d_qa;
    fwd_b = d_qb;
    if (d_rs != 5'd0) begin
      if (e_hit_rs & ~e_m2reg) fwd_a = ex_alu;
      else if (m_hit_rs)       fwd_a = m_data;
    end
    if (d_rt != 5'd0) begin
      if (e_hit_rt & ~e_m2reg) fwd_b = ex_alu;
      else if (m_hit_rt)       fwd_b = m_data;
    end
  end
`else
  assign stall_req = (src_rs & (e_hit_rs | m_hit_rs)) | (src_rt & (e_hit_rt | m_hit_rt));
  assign fwd_a     = d_qa;
  assign fwd_b     = d_qb;
  assign unused_in = ^{m_m2reg, ex_alu, m_data};
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      e_a       <= '0;
      e_b       <= '0;
      e_aluc    <= '0;
      e_rn      <= '0;
      e_valid   <= 1'b0;
      e_wreg    <= 1'b0;
      e_m2reg   <= 1'b0;
      e_wmem    <= 1'b0;
      stall_cnt <= '0;
    end else if (flush) begin
      e_valid <= 1'b0;
      e_wreg  <= 1'b0;
      e_m2reg <= 1'b0;
      e_wmem  <= 1'b0;
    end else if (!stall) begin
      if (stall_req) begin
        e_valid <= 1'b0;
        e_wreg  <= 1'b0;
        e_m2reg <= 1'b0;
        e_wmem  <= 1'b0;
        if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      end else begin
        e_a     <= d_shift ? {{(W-5){1'b0}}, d_sa} : fwd_a;
        e_b     <= d_aluimm ? d_imm : fwd_b;
        e_aluc  <= d_aluc;
        e_rn    <= d_rn;
        // an invalid slot loads as a bubble so no side effects leak downstream
        e_valid <= d_valid;
        e_wreg  <= d_valid & d_wreg;
        e_m2reg <= d_valid & d_m2reg;
        e_wmem  <= d_valid & d_wmem;
      end
    end
  end

endmodule

// File: tb/tb_exe_operand_stage.sv
// Directed bench for exe_operand_stage with a reference model feeding an expected-result queue.
// Works for either build of EXE_OPERAND_FWD_EN.
module tb_exe_operand_stage;
  localparam int W = 32;
`ifdef EXE_OPERAND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   aluc;
    logic [4:0]   rn;
    logic         valid;
    logic         wreg;
    logic         m2reg;
    logic         wmem;
    logic [15:0]  cnt;
  } exp_t;

  logic clock = 1'b0;
  logic resetn;
  logic d_valid, d_wreg, d_m2reg, d_wmem, d_aluimm, d_shift, d_use_rs, d_use_rt;
  logic [3:0] d_aluc;
  logic [4:0] d_rs, d_rt, d_rn, d_sa;
  logic [W-1:0] d_qa, d_qb, d_imm, ex_alu;
  logic m_wreg, m_m2reg;
  logic [4:0] m_rn;
  logic [W-1:0] m_data;
  logic stall, flush;
  logic [W-1:0] e_a, e_b;
  logic [3:0] e_aluc;
  logic e_wreg, e_m2reg, e_wmem, e_valid;
  logic [4:0] e_rn;
  logic stall_req;
  logic [15:0] stall_cnt;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t ms;
  exp_t sb[$];
  logic [15:0] cnt_before;

  always #5 clock = ~clock;

  exe_operand_stage #(.W(W)) dut (
    .clock(clock), .resetn(resetn),
    .d_valid(d_valid), .d_wreg(d_wreg), .d_m2reg(d_m2reg), .d_wmem(d_wmem),
    .d_aluimm(d_aluimm), .d_shift(d_shift), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
    .d_aluc(d_aluc), .d_rs(d_rs), .d_rt(d_rt), .d_rn(d_rn), .d_sa(d_sa),
    .d_qa(d_qa), .d_qb(d_qb), .d_imm(d_imm), .ex_alu(ex_alu),
    .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_rn(m_rn), .m_data(m_data),
    .stall(stall), .flush(flush),
    .e_a(e_a), .e_b(e_b), .e_aluc(e_aluc), .e_wreg(e_wreg), .e_m2reg(e_m2reg),
    .e_wmem(e_wmem), .e_valid(e_valid), .e_rn(e_rn),
    .stall_req(stall_req), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_sreq();
    logic hrs, hrt, ers, ert, mrs, mrt;
    hrs = d_valid && d_use_rs && (d_rs != 5'd0);
    hrt = d_valid && d_use_rt && (d_rt != 5'd0);
    ers = ms.valid && ms.wreg && (ms.rn == d_rs);
    ert = ms.valid && ms.wreg && (ms.rn == d_rt);
    mrs = m_wreg && (m_rn == d_rs);
    mrt = m_wreg && (m_rn == d_rt);
    if (FWD) return (hrs && ers && ms.m2reg) || (hrt && ert && ms.m2reg);
    return (hrs && (ers || mrs)) || (hrt && (ert || mrt));
  endfunction

  function automatic logic [W-1:0] model_fwd(input logic [4:0] r, input logic [W-1:0] q);
    if (!FWD || r == 5'd0) return q;
    if (ms.valid && ms.wreg && !ms.m2reg && ms.rn == r) return ex_alu;
    if (m_wreg && m_rn == r) return m_data;
    return q;
  endfunction

  function automatic exp_t model_next(input logic sreq);
    exp_t n;
    n = ms;
    if (flush || (!stall && sreq)) begin
      n.valid = 1'b0; n.wreg = 1'b0; n.m2reg = 1'b0; n.wmem = 1'b0;
      if (!flush && n.cnt != 16'hFFFF) n.cnt = n.cnt + 16'd1;
    end else if (!stall) begin
      n.a     = d_shift ? {27'd0, d_sa} : model_fwd(d_rs, d_qa);
      n.b     = d_aluimm ? d_imm : model_fwd(d_rt, d_qb);
      n.aluc  = d_aluc;
      n.rn    = d_rn;
      n.valid = d_valid;
      n.wreg  = d_valid & d_wreg;
      n.m2reg = d_valid & d_m2reg;
      n.wmem  = d_valid & d_wmem;
    end
    return n;
  endfunction

  task automatic cmp_out(input exp_t e);
    chk("e_valid", e_valid, e.valid);
    chk("e_wreg", e_wreg, e.wreg);
    chk("e_m2reg", e_m2reg, e.m2reg);
    chk("e_wmem", e_wmem, e.wmem);
    chk("stall_cnt", stall_cnt, e.cnt);
    if (e.valid) begin
      chk("e_a", e_a, e.a);
      chk("e_b", e_b, e.b);
      chk("e_aluc", e_aluc, e.aluc);
      chk("e_rn", e_rn, e.rn);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_e_a"}, e_a, '0);
    chk({tag, "_e_b"}, e_b, '0);
    chk({tag, "_e_aluc"}, e_aluc, '0);
    chk({tag, "_e_rn"}, e_rn, '0);
    chk({tag, "_ctrl"}, {e_valid, e_wreg, e_m2reg, e_wmem}, '0);
    chk({tag, "_cnt"}, stall_cnt, '0);
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic step();
    exp_t nx;
    logic sr;
    #1;
    sr = model_sreq();
    chk("stall_req", stall_req, sr);
    nx = model_next(sr);
    sb.push_back(nx);
    @(posedge clock);
    ms = nx;
    #1;
    cmp_out(sb.pop_front());
    @(negedge clock);
  endtask

  task automatic set_d(input logic v, wr, m2, wm, ai, sh, urs, urt,
                       input logic [3:0] op, input logic [4:0] rs, rt, rn, sa,
                       input logic [W-1:0] qa, qb, imm);
    d_valid = v; d_wreg = wr; d_m2reg = m2; d_wmem = wm; d_aluimm = ai; d_shift = sh;
    d_use_rs = urs; d_use_rt = urt; d_aluc = op; d_rs = rs; d_rt = rt; d_rn = rn; d_sa = sa;
    d_qa = qa; d_qb = qb; d_imm = imm;
  endtask

  task automatic set_m(input logic wr, input logic [4:0] rn, input logic [W-1:0] data);
    m_wreg = wr; m_m2reg = 1'b0; m_rn = rn; m_data = data;
  endtask

  // lw r4 into E, then a consumer of r4 -> one load-use bubble
  task automatic hazard();
    set_m(1'b0, 5'd0, '0);
    set_d(1, 1, 1, 0, 0, 0, 0, 0, 4'd0, 5'd0, 5'd0, 5'd4, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    set_d(1, 1, 0, 0, 0, 0, 0, 1, 4'd1, 5'd0, 5'd4, 5'd9, 5'd0, 32'h0, 32'h77, 32'h0);
    step();
  endtask

  initial begin
    resetn = 1'b0; stall = 1'b0; flush = 1'b0; ex_alu = '0;
    set_m(1'b0, 5'd0, '0);
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    ms = '0;
    #1;
    chk_zero("reset");
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;

    // E: add r3; ID: consumer of r3
    set_d(1, 1, 0, 0, 0, 0, 0, 0, 4'd2, 5'd0, 5'd0, 5'd3, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    ex_alu = 32'h0000_0010;
    set_d(1, 1, 0, 0, 0, 0, 1, 0, 4'd2, 5'd3, 5'd0, 5'd6, 5'd0, 32'h5, 32'h0, 32'h0);
    #1;
    chk("r27_sreq", stall_req, !FWD);
    step();
    chk("r27_first_valid", e_valid, FWD);
    chk("r27_first_e_a", e_a, FWD ? 32'h10 : 32'h0);
    step();
    chk("r27_then_e_a", e_a, 32'h5);

    // shift amount and immediate operand selection
    set_d(1, 1, 0, 0, 1, 1, 0, 0, 4'd5, 5'd0, 5'd0, 5'd7, 5'd7, 32'h99, 32'h98, 32'h1234);
    step();
    chk("sa_e_a", e_a, 32'h7);
    chk("imm_e_b", e_b, 32'h1234);

    // load-use on rt, then the load result arrives from M
    set_d(1, 1, 1, 0, 0, 0, 0, 0, 4'd0, 5'd0, 5'd0, 5'd4, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    cnt_before = ms.cnt;
    set_d(1, 0, 0, 1, 0, 0, 0, 1, 4'd3, 5'd0, 5'd4, 5'd8, 5'd0, 32'h0, 32'h111, 32'h0);
    #1;
    chk("r28_sreq", stall_req, 1'b1);
    step();
    chk("r28_bubble", e_valid, 1'b0);
    chk("r28_cnt", stall_cnt, cnt_before + 16'd1);
    set_m(1'b1, 5'd4, 32'hABC);
    step();
    chk("r28_load_valid", e_valid, FWD);
    set_m(1'b0, 5'd0, '0);
    step();
    chk("r28_final_valid", e_valid, 1'b1);

    // E and M both write r5: E wins
    set_d(1, 1, 0, 0, 0, 0, 0, 0, 4'd2, 5'd0, 5'd0, 5'd5, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    ex_alu = 32'h7;
    set_m(1'b1, 5'd5, 32'h9);
    set_d(1, 1, 0, 0, 0, 0, 1, 0, 4'd2, 5'd5, 5'd0, 5'd6, 5'd0, 32'h1, 32'h0, 32'h0);
    step();
    chk("r29_e_valid", e_valid, FWD);
    chk("r29_e_a", e_a, FWD ? 32'h7 : 32'h0);
    set_m(1'b0, 5'd0, '0);
    step();
    // r0 sources are never forwarded even when rn=0 matches
    set_d(1, 1, 0, 0, 0, 0, 0, 0, 4'd2, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    ex_alu = 32'hDEAD;
    set_m(1'b1, 5'd0, 32'h9);
    set_d(1, 1, 0, 0, 0, 0, 1, 0, 4'd2, 5'd0, 5'd0, 5'd6, 5'd0, 32'h33, 32'h0, 32'h0);
    step();
    chk("r29_r0_e_a", e_a, 32'h33);
    set_m(1'b0, 5'd0, '0);

    // flush beats stall
    stall = 1'b1; flush = 1'b1;
    step();
    chk("r30_flush_bubble", e_valid, 1'b0);
    stall = 1'b0; flush = 1'b0;
    // stall beats stall_req: hold, no count
    set_d(1, 1, 1, 0, 0, 0, 0, 0, 4'd0, 5'd0, 5'd0, 5'd4, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    cnt_before = ms.cnt;
    set_d(1, 1, 0, 0, 0, 0, 1, 0, 4'd1, 5'd4, 5'd0, 5'd9, 5'd0, 32'h0, 32'h0, 32'h0);
    stall = 1'b1;
    step();
    chk("r30_hold_valid", e_valid, 1'b1);
    chk("r30_hold_rn", e_rn, 5'd4);
    chk("r30_hold_cnt", stall_cnt, cnt_before);
    stall = 1'b0;
    step();
    chk("r30_release_cnt", stall_cnt, cnt_before + 16'd1);

    // saturation
    force dut.stall_cnt = 16'hFFFE;
    #1;
    release dut.stall_cnt;
    ms.cnt = 16'hFFFE;
    chk("r31_preload", stall_cnt, 16'hFFFE);
    @(negedge clock);
    hazard();
    chk("r31_hit_max", stall_cnt, 16'hFFFF);
    hazard();
    chk("r31_saturate", stall_cnt, 16'hFFFF);

    // reset mid-stall discards the held instruction
    set_d(1, 1, 0, 1, 0, 0, 0, 0, 4'd6, 5'd0, 5'd0, 5'd12, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    stall = 1'b1;
    step();
    #2;
    resetn = 1'b0;
    #1;
    chk_zero("r26_async");
    ms = '0;
    sb.delete();
    @(negedge clock);
    resetn = 1'b1;
    step();
    chk("r23_discarded", e_valid, 1'b0);
    stall = 1'b0;
    step();
    chk("r23_first_capture", e_valid, 1'b1);
    chk("r23_first_rn", e_rn, 5'd12);

    // invalid slot loads as a bubble
    set_d(0, 1, 1, 1, 0, 0, 0, 0, 4'd1, 5'd0, 5'd0, 5'd3, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    chk("r18_ctrl", {e_valid, e_wreg, e_m2reg, e_wmem}, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/exe_operand_stage.md
EXE_OPERAND_STAGE -- requirements
Module: exe_operand_stage

Interface
REQ-001 The block SHALL have parameter W, default 32, the datapath width.
REQ-002 The block SHALL have port clock  in  1  the rising-edge clock.
REQ-003 The block SHALL have port resetn  in  1  the reset, asynchronous and active-low.
REQ-004 The block SHALL have port d_valid, d_wreg, d_m2reg, d_wmem, d_aluimm, d_shift, d_use_rs, d_use_rt  in  1 each  the decoded ID-stage controls.
REQ-005 The block SHALL have port d_aluc  in  4  the ALU opcode; d_rs, d_rt, d_rn, d_sa  in  5 each; d_qa, d_qb, d_imm  in  W each.
REQ-006 The block SHALL have port ex_alu  in  W  the current ALU result of the E stage.
REQ-007 The block SHALL have port m_wreg, m_m2reg  in  1 each; m_rn  in  5; m_data  in  W  the final M-stage result (mux already applied).
REQ-008 The block SHALL have port stall  in  1  the downstream hold request; flush  in  1  the bubble request.
REQ-009 The block SHALL have port e_a, e_b  out  W; e_aluc  out  4; e_wreg, e_m2reg, e_wmem, e_valid  out  1 each; e_rn  out  5.
REQ-010 The block SHALL have port stall_req  out  1  combinational upstream hold (load-use hazard).
REQ-011 The block SHALL have port stall_cnt  out  16  the count of hazard bubbles.

Function
REQ-012 The block SHALL treat rs as a hazard source only if d_valid, d_use_rs and rs!=0 (same rule for rt with d_use_rt).
REQ-013 The block SHALL raise stall_req = hazard(rs) | hazard(rt) when e_valid, e_wreg and e_m2reg are set and e_rn matches the source.
REQ-014 The block SHALL forward operand A with priority: E match (e_valid, e_wreg, !e_m2reg, e_rn==rs) -> ex_alu; else M match (m_wreg, m_rn==rs) -> m_data; else d_qa. The same rule SHALL apply to operand B with rt/d_qb.
REQ-015 The block SHALL load e_a = d_shift ? zero-extended d_sa : fwdA, and e_b = d_aluimm ? d_imm : fwdB.
REQ-016 The block SHALL apply this per-edge priority: flush -> bubble; else stall -> hold all outputs; else stall_req -> bubble; else load all d_* fields.
REQ-017 A bubble SHALL clear e_valid, e_wreg, e_m2reg and e_wmem, and SHALL leave e_a, e_b, e_aluc and e_rn don't-care (implementation holds them).
REQ-018 Loading with d_valid=0 SHALL produce a bubble.
REQ-019 Latency SHALL be one cycle from the d_* inputs to the e_* outputs; stall_req SHALL have zero latency.
REQ-020 stall_cnt SHALL increment by 1 on each edge taking the stall_req-bubble branch, and SHALL saturate at 16'hFFFF without wrapping.
REQ-021 When stall and stall_req are both high, the block SHALL hold and SHALL NOT increment stall_cnt.

Reset
REQ-022 When resetn is low, all e_* outputs and stall_cnt SHALL go to 0 immediately, regardless of clock.
REQ-023 The first capture after reset release SHALL occur on the first rising edge with resetn high; reset mid-stall SHALL discard the held instruction.

Configuration
REQ-024 With macro EXE_OPERAND_FWD_EN defined, the block SHALL forward per REQ-014.
REQ-025 With EXE_OPERAND_FWD_EN undefined, the block SHALL use d_qa/d_qb unmodified, and stall_req SHALL also assert on any RAW match against the E stage (e_valid, e_wreg) or the M stage (m_wreg) regardless of m2reg.

Verification
REQ-026 Reset low mid-stream -> all e_* outputs and stall_cnt = 0 immediately.
REQ-027 E stage add to r3 (ex_alu=32'h0000_0010), ID reads rs=r3, d_qa=32'h5 -> next e_a = 32'h10; with FWD_EN off -> stall_req=1, one bubble, then e_a = d_qa.
REQ-028 E stage lw to r4, ID uses rt=r4 -> stall_req=1, e_valid=0 next cycle, stall_cnt=1; instruction loads on the following cycle with e_b = m_data.
REQ-029 E and M both writing r5 with ex_alu=7 and m_data=9 -> e_a = 7 (E priority); rs=r0 with a matching rn=0 -> e_a = d_qa.
REQ-030 stall=1 and flush=1 on the same edge -> bubble; stall=1 with stall_req=1 -> outputs hold and stall_cnt unchanged.
REQ-031 Preload stall_cnt near 16'hFFFF (force), then two further hazards -> stall_cnt stays at 16'hFFFF.
